// File: rtl/taylor_sweep_ctrl.sv
// taylor_sweep_ctrl: requester-side sweep controller for the Taylor/Horner
// cosine core. Walks first + k*step for sweep_count points, runs one core
// request per point and queues {angle, cos} pairs in a first-word
// fall-through FIFO behind a valid/ready result port.
//
// Optional feature macro: SWEEP_TIMEOUT_EN
//   defined   - WAIT aborts the sweep after TIMEOUT cycles without a ready
//               edge and raises the sticky err_timeout flag.
//   undefined - WAIT waits indefinitely, err_timeout is tied low.
module taylor_sweep_ctrl #(
    parameter int W            = 24,
    parameter int FRAC         = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int START_CYCLES = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sweep_go,
    input  logic [W-1:0] angle_first,
    input  logic [W-1:0] angle_step,
    input  logic [7:0]   sweep_count,
    output logic         busy,
    output logic         done,
    output logic         core_start,
    output logic [W-1:0] core_angle,
    input  logic         core_ready,
    input  logic [W-1:0] core_cos,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_angle,
    output logic [W-1:0] res_cos,
    output logic         err_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES + 1) : 1;

    // Reject configurations the FIFO pointers and start counter cannot handle.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            START_CYCLES < 1 || FRAC > W || TIMEOUT < 1) begin : g_bad_params
            $error("taylor_sweep_ctrl: illegal parameter set");
        end
    endgenerate

    // FSM and sweep bookkeeping
    logic [2:0]     state_q, state_d;
    logic [W-1:0]   cur_q, cur_d;
    logic [W-1:0]   step_q, step_d;
    logic [7:0]     rem_q, rem_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [W-1:0]   angle_q, angle_d;
    logic           rdy_q;

    // FIFO
    logic [W-1:0]   mem_angle [FIFO_DEPTH];
    logic [W-1:0]   mem_cos   [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  cnt_q;

    logic full, empty, push, pop, rise, enter_issue;

    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign empty  = (cnt_q == '0);
    assign push   = (state_q == S_CAPT) && !full;
    assign pop    = !empty && res_ready;
    // A ready level that is already high is ignored; only a fresh low->high
    // transition relative to the previous cycle completes a request.
    assign rise   = core_ready && !rdy_q;
    assign enter_issue = (state_d == S_ISSUE) && (state_q != S_ISSUE);

`ifdef SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    // Next-state logic for the sweep FSM
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        step_d  = step_q;
        rem_d   = rem_q;
        scnt_d  = scnt_q;
        angle_d = angle_q;
`ifdef SWEEP_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sweep_go) begin
                    cur_d  = angle_first;
                    step_d = angle_step;
                    rem_d  = sweep_count;
`ifdef SWEEP_TIMEOUT_EN
                    err_d  = 1'b0;
`endif
                    if (sweep_count == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        angle_d = angle_first;
                    end
                end
            end
            S_ISSUE: begin
`ifdef SWEEP_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (scnt_q == SCW'(START_CYCLES - 1)) begin
                    scnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (rise) begin
                    state_d = S_CAPT;
`ifdef SWEEP_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Abandon the remaining points; nothing is pushed.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            S_CAPT: begin
                // With the FIFO full we simply hold here; the core keeps
                // core_cos stable until it sees another start.
                if (!full) begin
                    rem_d = rem_q - 8'd1;
                    cur_d = cur_q + step_q;
                    if (rem_q == 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        angle_d = cur_q + step_q;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and sweep registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            scnt_q  <= '0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            scnt_q  <= scnt_d;
            angle_q <= angle_d;
        end
    end

    // Delayed core_ready for edge detection, cleared when a new request starts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= enter_issue ? 1'b0 : core_ready;
        end
    end

`ifdef SWEEP_TIMEOUT_EN
    // WAIT watchdog and sticky timeout flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // FIFO storage; contents are only visible while res_valid is high
    always_ff @(posedge clock) begin
        if (push) begin
            mem_angle[wr_q] <= cur_q;
            mem_cos[wr_q]   <= core_cos;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign core_start = (state_q == S_ISSUE);
    assign core_angle = angle_q;
    assign res_valid  = !empty;
    assign res_angle  = empty ? '0 : mem_angle[rd_q];
    assign res_cos    = empty ? '0 : mem_cos[rd_q];

endmodule
